frac_clk_enable_manager: RTL and testbench

// Synthesizable, multi-channel successor to our vendor-PLL clock wrapper.

---
 rtl/frac_clk_pkg.sv | 20 ++
 rtl/frac_clk_channel.sv | 128 ++++++++++++
 rtl/frac_clk_enable_manager.sv | 71 +++++++
 tb/tb_frac_clk_enable_manager.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/frac_clk_pkg.sv
// Shared types and constants for the fractional clock-enable manager.
// Ratio presets are num/den pairs for a 50 MHz system clock and need ACC_W >= 11.
package frac_clk_pkg;

  typedef enum logic [1:0] {
    OFF     = 2'd0,
    LOCKING = 2'd1,
    LOCKED  = 2'd2
  } ch_state_t;

  localparam int DEFAULT_LOCK_CYCLES = 16;

  localparam int VGA_640X480_NUM  = 1007;
  localparam int VGA_640X480_DEN  = 2000;
  localparam int SVGA_800X600_NUM = 4;
  localparam int SVGA_800X600_DEN = 5;
  localparam int PIX_29M5_NUM     = 59;
  localparam int PIX_29M5_DEN     = 100;

endpackage

// File: rtl/frac_clk_channel.sv
// One fractional enable channel: lock-emulation FSM, phase accumulator, lock counter
// and a pending ratio that is applied on the next accumulator wrap.
module frac_clk_channel
  import frac_clk_pkg::*;
#(
  parameter int ACC_W       = 12,
  parameter int LOCK_CYCLES = DEFAULT_LOCK_CYCLES
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic             i_off,
  input  logic [ACC_W-1:0] i_num,
  input  logic [ACC_W-1:0] i_den,
  output logic             o_clk_en,
  output logic             o_locked,
  output logic             o_enabled,
  output logic             o_pend
);

  localparam int CNT_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LOCK_CYCLES - 1);

  ch_state_t        r_state, w_state_next;
  logic [ACC_W-1:0] r_acc, w_acc_next;
  logic [ACC_W-1:0] r_num, w_num_next, r_den, w_den_next;
  logic [ACC_W-1:0] r_pnum, w_pnum_next, r_pden, w_pden_next;
  logic [CNT_W-1:0] r_cnt, w_cnt_next;
  logic             r_pend, w_pend_next;
  logic             r_clk_en, w_clk_en_next;
  logic             r_locked;
  logic [ACC_W:0]   w_sum, w_diff;
  logic             w_wrap;
  logic [ACC_W-1:0] w_acc_step;

  // Sum kept one bit wider so num + acc never overflows before the compare.
  assign w_sum      = {1'b0, r_acc} + {1'b0, r_num};
  assign w_diff     = w_sum - {1'b0, r_den};
  assign w_wrap     = (w_sum >= {1'b0, r_den});
  assign w_acc_step = w_wrap ? w_diff[ACC_W-1:0] : w_sum[ACC_W-1:0];

  always_comb begin
    w_state_next  = r_state;
    w_acc_next    = r_acc;
    w_num_next    = r_num;
    w_den_next    = r_den;
    w_pnum_next   = r_pnum;
    w_pden_next   = r_pden;
    w_cnt_next    = r_cnt;
    w_pend_next   = r_pend;
    w_clk_en_next = 1'b0;

    case (r_state)
      LOCKING: begin
        w_acc_next = w_acc_step;
        if (r_cnt == '0) w_state_next = LOCKED;
        else             w_cnt_next   = r_cnt - 1'b1;
      end
      LOCKED: begin
        w_acc_next = w_acc_step;
        if (r_pend && w_wrap) begin
          // Retune lands on a wrap so the old ratio never emits a short period.
          w_acc_next   = '0;
          w_num_next   = r_pnum;
          w_den_next   = r_pden;
          w_cnt_next   = CNT_INIT;
          w_pend_next  = 1'b0;
          w_state_next = LOCKING;
        end else begin
          w_clk_en_next = w_wrap;
        end
      end
      default: ;
    endcase

    if (i_off) begin
      w_state_next  = OFF;
      w_acc_next    = '0;
      w_pend_next   = 1'b0;
      w_clk_en_next = 1'b0;
    end else if (i_load) begin
      if (r_state == LOCKED) begin
        w_pend_next = 1'b1;
        w_pnum_next = i_num;
        w_pden_next = i_den;
      end else begin
        w_num_next    = i_num;
        w_den_next    = i_den;
        w_acc_next    = '0;
        w_cnt_next    = CNT_INIT;
        w_state_next  = LOCKING;
        w_clk_en_next = 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state  <= OFF;
      r_acc    <= '0;
      r_num    <= '0;
      r_den    <= '0;
      r_pnum   <= '0;
      r_pden   <= '0;
      r_cnt    <= '0;
      r_pend   <= 1'b0;
      r_clk_en <= 1'b0;
      r_locked <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_acc    <= w_acc_next;
      r_num    <= w_num_next;
      r_den    <= w_den_next;
      r_pnum   <= w_pnum_next;
      r_pden   <= w_pden_next;
      r_cnt    <= w_cnt_next;
      r_pend   <= w_pend_next;
      r_clk_en <= w_clk_en_next;
      r_locked <= (w_state_next == LOCKED);
    end
  end

  assign o_clk_en  = r_clk_en;
  assign o_locked  = r_locked;
  assign o_enabled = (r_state != OFF);
  assign o_pend    = r_pend;

endmodule

// File: rtl/frac_clk_enable_manager.sv
// Multi-channel fractional clock-enable generator: decodes and validates config
// requests, fans them out to per-channel generators and summarises lock status.
module frac_clk_enable_manager
  import frac_clk_pkg::*;
#(
  parameter  int NUM_CH      = 4,
  parameter  int ACC_W       = 12,
  parameter  int LOCK_CYCLES = DEFAULT_LOCK_CYCLES,
  localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_cfg_valid,
  output logic              o_cfg_ready,
  input  logic [CH_W-1:0]   i_cfg_ch,
  input  logic              i_cfg_en,
  input  logic [ACC_W-1:0]  i_cfg_num,
  input  logic [ACC_W-1:0]  i_cfg_den,
  output logic              o_cfg_err,
  output logic [NUM_CH-1:0] o_clk_en,
  output logic [NUM_CH-1:0] o_locked,
  output logic              o_all_locked
);

  logic              w_accept, w_ch_ok, w_bad_ratio, w_req_ok;
  logic [NUM_CH-1:0] w_load, w_off, w_enabled, w_pend;
  logic              r_cfg_err, r_all_locked;

  assign o_cfg_ready = ~|w_pend;
  assign w_accept    = i_cfg_valid & o_cfg_ready;
  assign w_ch_ok     = ({1'b0, i_cfg_ch} < (CH_W + 1)'(NUM_CH));
  assign w_bad_ratio = i_cfg_en & ((i_cfg_den == '0) | (i_cfg_num == '0) | (i_cfg_num > i_cfg_den));
  assign w_req_ok    = w_accept & w_ch_ok & ~w_bad_ratio;

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      assign w_load[gi] = w_req_ok &  i_cfg_en & (i_cfg_ch == CH_W'(gi));
      assign w_off[gi]  = w_req_ok & ~i_cfg_en & (i_cfg_ch == CH_W'(gi));

      frac_clk_channel #(
        .ACC_W       (ACC_W),
        .LOCK_CYCLES (LOCK_CYCLES)
      ) u_ch (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_load    (w_load[gi]),
        .i_off     (w_off[gi]),
        .i_num     (i_cfg_num),
        .i_den     (i_cfg_den),
        .o_clk_en  (o_clk_en[gi]),
        .o_locked  (o_locked[gi]),
        .o_enabled (w_enabled[gi]),
        .o_pend    (w_pend[gi])
      );
    end
  endgenerate

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cfg_err    <= 1'b0;
      r_all_locked <= 1'b0;
    end else begin
      r_cfg_err    <= w_accept & ~(w_ch_ok & ~w_bad_ratio);
      r_all_locked <= (|w_enabled) & (&(~w_enabled | o_locked));
    end
  end

  assign o_cfg_err    = r_cfg_err;
  assign o_all_locked = r_all_locked;

endmodule

// File: tb/tb_frac_clk_enable_manager.sv
// Directed scenarios plus random requests checked cycle-by-cycle against an
// arithmetic reference model (strobe k after load occurs when floor(k*num/den) steps).
module tb_frac_clk_enable_manager;

  localparam int NCH = 3;
  localparam int AW  = 12;
  localparam int LC  = 16;
  localparam int CHW = 2;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           cfg_valid = 1'b0;
  logic           cfg_en = 1'b0;
  logic [CHW-1:0] cfg_ch = '0;
  logic [AW-1:0]  cfg_num = '0;
  logic [AW-1:0]  cfg_den = '0;
  logic           cfg_ready, cfg_err, all_locked;
  logic [NCH-1:0] clk_en, locked;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  frac_clk_enable_manager #(
    .NUM_CH      (NCH),
    .ACC_W       (AW),
    .LOCK_CYCLES (LC)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_cfg_valid  (cfg_valid),
    .o_cfg_ready  (cfg_ready),
    .i_cfg_ch     (cfg_ch),
    .i_cfg_en     (cfg_en),
    .i_cfg_num    (cfg_num),
    .i_cfg_den    (cfg_den),
    .o_cfg_err    (cfg_err),
    .o_clk_en     (clk_en),
    .o_locked     (locked),
    .o_all_locked (all_locked)
  );

  // Reference model: per channel, steps since the ratio was loaded.
  bit     m_active[NCH];
  longint m_j[NCH], m_num[NCH], m_den[NCH], m_pnum[NCH], m_pden[NCH];
  bit     m_pend[NCH], m_en[NCH], m_lk[NCH];
  bit     m_all, m_err;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit wrap_at(longint k, longint num, longint den);
    return ((k * num) / den) != (((k - 1) * num) / den);
  endfunction

  function automatic bit m_ready();
    for (int c = 0; c < NCH; c++) if (m_pend[c]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_edge(input bit acc, input bit rst_ok);
    bit     any_act, all_ok, pre_act, w, bad;
    longint pre_j;
    int     ch;
    if (!rst_ok) begin
      for (int c = 0; c < NCH; c++) begin
        m_active[c] = 0; m_j[c] = 0; m_pend[c] = 0; m_en[c] = 0; m_lk[c] = 0;
      end
      m_all = 0; m_err = 0;
      return;
    end
    any_act = 0; all_ok = 1;
    for (int c = 0; c < NCH; c++)
      if (m_active[c]) begin
        any_act = 1;
        if (!m_lk[c]) all_ok = 0;
      end
    ch  = int'(cfg_ch);
    bad = (ch >= NCH) || (cfg_en && (cfg_den == 0 || cfg_num == 0 || cfg_num > cfg_den));
    for (int c = 0; c < NCH; c++) begin
      pre_act = m_active[c];
      pre_j   = m_j[c];
      if (m_active[c]) begin
        w = wrap_at(m_j[c] + 1, m_num[c], m_den[c]);
        if (m_pend[c] && m_j[c] >= LC && w) begin
          m_num[c] = m_pnum[c]; m_den[c] = m_pden[c]; m_j[c] = 0; m_pend[c] = 0; m_en[c] = 0;
        end else begin
          m_en[c] = w && (m_j[c] >= LC);
          m_j[c]++;
        end
      end else m_en[c] = 0;
      if (acc && !bad && ch == c) begin
        if (!cfg_en) begin
          m_active[c] = 0; m_j[c] = 0; m_pend[c] = 0; m_en[c] = 0;
        end else if (!pre_act || pre_j < LC) begin
          m_active[c] = 1; m_j[c] = 0; m_num[c] = cfg_num; m_den[c] = cfg_den; m_en[c] = 0;
        end else begin
          m_pend[c] = 1; m_pnum[c] = cfg_num; m_pden[c] = cfg_den;
        end
      end
      m_lk[c] = m_active[c] && (m_j[c] >= LC);
    end
    m_all = any_act && all_ok;
    m_err = acc && bad;
  endtask

  task automatic compare();
    logic [NCH-1:0] e_en, e_lk;
    for (int c = 0; c < NCH; c++) begin
      e_en[c] = m_en[c];
      e_lk[c] = m_lk[c];
    end
    chk("clk_en", clk_en, e_en);
    chk("locked", locked, e_lk);
    chk("all_locked", all_locked, m_all);
    chk("cfg_err", cfg_err, m_err);
    chk("cfg_ready", cfg_ready, m_ready());
  endtask

  task automatic tick();
    bit acc;
    acc = cfg_valid && m_ready();
    @(posedge clk);
    model_edge(acc, rst_n);
    #1;
    compare();
  endtask

  task automatic send_req(input int ch, input bit en, input int num, input int den);
    int w = 0;
    cfg_valid = 1'b1;
    cfg_ch    = CHW'(ch);
    cfg_en    = en;
    cfg_num   = AW'(num);
    cfg_den   = AW'(den);
    while (!cfg_ready && w < 5000) begin
      tick();
      w++;
    end
    if (w >= 5000) chk("ready_timeout", cfg_ready, 1'b1);
    $display("req ch=%0d en=%0d num=%0d den=%0d wait=%0d", ch, en, num, den, w);
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic count_strobes(input int ch, input int n, output int cnt);
    cnt = 0;
    for (int k = 0; k < n; k++) begin
      tick();
      cnt += int'(clk_en[ch]);
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int first_lock, first_all, cnt, cnt0, last, max_int, n, k;

    // 1. reset
    rst_n = 1'b0;
    tick(); tick();
    chk("rst_clk_en", clk_en, 0);
    chk("rst_locked", locked, 0);
    chk("rst_all_locked", all_locked, 0);
    chk("rst_cfg_err", cfg_err, 0);
    chk("rst_cfg_ready", cfg_ready, 1);
    rst_n = 1'b1;
    tick();

    // 2. ch0 at 1/2
    send_req(0, 1, 1, 2);
    first_lock = -1; first_all = -1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (locked[0] && first_lock < 0) first_lock = i;
      if (all_locked && first_all < 0) first_all = i;
    end
    chk("t2_lock_cycle", first_lock, 16);
    chk("t2_all_locked_cycle", first_all, 17);
    count_strobes(0, 100, cnt);
    chk("t2_strobes_100", cnt, 50);

    // 3. ch1 at 59/100
    send_req(1, 1, 59, 100);
    for (int i = 0; i < 20; i++) tick();
    cnt = 0; cnt0 = 0; last = -1; max_int = 0;
    for (int i = 0; i < 1000; i++) begin
      tick();
      cnt0 += int'(clk_en[0]);
      if (clk_en[1]) begin
        cnt++;
        if (last >= 0 && i - last > max_int) max_int = i - last;
        last = i;
      end
    end
    chk("t3_strobes_1000", cnt, 590);
    chk("t3_max_interval", max_int, 2);
    chk("t3_ch0_strobes", cnt0, 500);

    // 4. retune locked ch0 to 4/5
    send_req(0, 1, 4, 5);
    chk("t4_ready_low", cfg_ready, 0);
    k = 0;
    while (locked[0] && k < 10) begin tick(); k++; end
    n = 0;
    while (!locked[0] && n < 40) begin n++; tick(); end
    chk("t4_unlocked_cycles", n, 16);
    count_strobes(0, 100, cnt);
    chk("t4_strobes_100", cnt, 80);

    // 5. invalid requests
    cnt = 0;
    send_req(1, 1, 1, 0);   cnt += int'(cfg_err); tick(); cnt += int'(cfg_err);
    send_req(1, 1, 7, 5);   cnt += int'(cfg_err); tick(); cnt += int'(cfg_err);
    send_req(NCH, 1, 1, 2); cnt += int'(cfg_err); tick(); cnt += int'(cfg_err);
    chk("t5_err_pulses", cnt, 3);

    // 6. num == den, disable, reset mid-LOCKING
    send_req(2, 1, 5, 5);
    for (int i = 0; i < 20; i++) tick();
    cnt = 0;
    for (int i = 0; i < 20; i++) begin tick(); cnt += int'(clk_en[2]); end
    chk("t6_full_rate", cnt, 20);
    send_req(2, 0, 0, 0);
    chk("t6_disabled", clk_en[2], 0);
    chk("t6_disabled_lock", locked[2], 0);
    send_req(2, 1, 5, 5);
    for (int i = 0; i < 5; i++) tick();
    rst_n = 1'b0;
    tick();
    chk("t6_rst_clk_en", clk_en, 0);
    chk("t6_rst_locked", locked, 0);
    chk("t6_rst_all_locked", all_locked, 0);
    chk("t6_rst_ready", cfg_ready, 1);
    rst_n = 1'b1;
    tick();

    // 7. random requests
    for (int r = 0; r < 150; r++) begin
      int ch, den, num;
      bit en;
      ch  = int'($urandom_range(0, NCH));
      en  = ($urandom_range(0, 3) != 0);
      den = int'($urandom_range(0, 40));
      num = int'($urandom_range(0, den + 2));
      send_req(ch, en, num, den);
      for (int g = int'($urandom_range(0, 25)); g > 0; g--) tick();
      if ($urandom_range(0, 39) == 0) begin
        $display("reset pulse");
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
      end
    end
    for (int i = 0; i < 50; i++) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
